// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial sequence detector.
// Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per
// clock on x, qualified by x_valid. Words stream back-to-back without idle gaps.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_busy;
    logic             w_ready;
    logic             w_accept;

    assign w_busy   = (r_state == SHIFT);
    assign w_ready  = !w_busy || r_last;
    assign w_accept = din_valid && w_ready;

    // The shift register fills with zeros as it drains, so once a word has been
    // fully shifted out (or after reset) the output bit reads 0 with no gating.
    assign x         = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign x_valid   = w_busy;
    assign busy      = w_busy;
    assign last      = r_last;
    assign din_ready = w_ready;

    // State and datapath registers; reset has priority over any transfer.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state: drain one bit per cycle in SHIFT, reload on any accepted word.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;

        if (r_state == SHIFT) begin
            w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            if (r_last) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_last_nxt  = 1'b0;
            end else begin
                w_cnt_nxt  = r_cnt - CW'(1);
                w_last_nxt = (r_cnt == CW'(1));
            end
        end

        // A transfer at the final bit overrides the return to IDLE.
        if (w_accept) begin
            w_state_nxt = SHIFT;
            w_shreg_nxt = din;
            w_cnt_nxt   = CNT_LOAD;
            w_last_nxt  = (WIDTH == 1);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: three configurations (8-bit MSB-first, 8-bit
// LSB-first, 1-bit) checked every cycle against a queue-based reference model,
// plus literal bit-stream expectations for the directed scenarios.
module tb_bit_serializer;

    logic       clk;
    logic       res;
    logic [7:0] din8;
    logic       dv8;
    logic [0:0] din1;
    logic       dv1;

    logic rdy0, x0, xv0, last0, busy0;
    logic rdy1, x1, xv1, last1, busy1;
    logic rdy2, x2, xv2, last2, busy2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    bit cap0[$];
    bit cap1[$];
    bit cap2[$];

    // Reference model: per instance, the queue of bits still to appear on x.
    bit mq[3][64];
    int mlen[3];
    bit macc[3];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .res(res), .din(din8), .din_valid(dv8), .din_ready(rdy0),
        .x(x0), .x_valid(xv0), .last(last0), .busy(busy0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .res(res), .din(din8), .din_valid(dv8), .din_ready(rdy1),
        .x(x1), .x_valid(xv1), .last(last1), .busy(busy1)
    );

    bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .res(res), .din(din1), .din_valid(dv1), .din_ready(rdy2),
        .x(x2), .x_valid(xv2), .last(last2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit v, input logic [7:0] d);
        int  w;
        bit  msb;
        bit  rdy;
        w   = (i == 2) ? 1 : 8;
        msb = (i != 1);
        rdy = (mlen[i] <= 1);
        macc[i] = 1'b0;
        if (r) begin
            mlen[i] = 0;
        end else begin
            if (mlen[i] > 0) begin
                for (int k = 0; k < mlen[i] - 1; k++) mq[i][k] = mq[i][k+1];
                mlen[i]--;
            end
            if (v && rdy) begin
                macc[i] = 1'b1;
                for (int k = 0; k < w; k++) begin
                    mq[i][mlen[i]] = msb ? d[w-1-k] : d[k];
                    mlen[i]++;
                end
            end
        end
    endtask

    // Model advances on every rising edge using the inputs seen at that edge.
    initial begin
        for (int i = 0; i < 3; i++) mlen[i] = 0;
        forever begin
            @(posedge clk);
            model_step(0, res, dv8, din8);
            model_step(1, res, dv8, din8);
            model_step(2, res, dv1, {7'b0, din1});
        end
    end

    task automatic cmp_inst(input int i, input logic ax, input logic axv,
                            input logic alast, input logic abusy, input logic ardy);
        bit ex;
        ex = (mlen[i] > 0) ? mq[i][0] : 1'b0;
        chk($sformatf("x[%0d]", i),         {31'b0, ax},    {31'b0, ex});
        chk($sformatf("x_valid[%0d]", i),   {31'b0, axv},   {31'b0, mlen[i] > 0});
        chk($sformatf("last[%0d]", i),      {31'b0, alast}, {31'b0, mlen[i] == 1});
        chk($sformatf("busy[%0d]", i),      {31'b0, abusy}, {31'b0, mlen[i] > 0});
        chk($sformatf("din_ready[%0d]", i), {31'b0, ardy},  {31'b0, mlen[i] <= 1});
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp_inst(0, x0, xv0, last0, busy0, rdy0);
                cmp_inst(1, x1, xv1, last1, busy1, rdy1);
                cmp_inst(2, x2, xv2, last2, busy2, rdy2);
                if (xv0) cap0.push_back(x0);
                if (xv1) cap1.push_back(x1);
                if (xv2) cap2.push_back(x2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] w);
        din8 = w;
        dv8  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (macc[0]) break;
        end
        chk("accept_within_bound", {31'b0, macc[0]}, 32'd1);
    endtask

    task automatic clear_caps();
        cap0.delete();
        cap1.delete();
        cap2.delete();
    endtask

    task automatic chk_cap(input string nm, input int which, input int n, input logic [15:0] exp);
        bit          q[$];
        logic [15:0] v;
        if (which == 0) q = cap0;
        else if (which == 1) q = cap1;
        else q = cap2;
        v = '0;
        for (int k = 0; k < q.size(); k++) v = {v[14:0], q[k]};
        chk({nm, "_len"}, q.size(), n);
        chk(nm, {16'b0, v}, {16'b0, exp});
    endtask

    initial begin
        res  = 1'b1;
        din8 = '0;
        dv8  = 1'b0;
        din1 = '0;
        dv1  = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_din_ready", {31'b0, rdy0}, 32'd1);
        chk("rst_busy",      {31'b0, busy0}, 32'd0);
        chk("rst_x_valid",   {31'b0, xv0}, 32'd0);
        tick();
        res = 1'b0;

        // Single word, both bit orders.
        clear_caps();
        send8(8'hB6);
        dv8 = 1'b0;
        repeat (12) tick();
        chk_cap("t1_msb_B6", 0, 8, 16'h00B6);
        chk_cap("t1_lsb_B6", 1, 8, 16'h006D);

        // Back-to-back words with valid held high.
        clear_caps();
        send8(8'hB0);
        send8(8'h2C);
        dv8 = 1'b0;
        repeat (20) tick();
        chk_cap("t2_b2b", 0, 16, 16'hB02C);

        // Valid raised mid-word is held off until the last bit.
        clear_caps();
        send8(8'h00);
        dv8 = 1'b0;
        repeat (3) tick();
        send8(8'hFF);
        dv8 = 1'b0;
        repeat (12) tick();
        chk_cap("t3_hold", 0, 16, 16'h00FF);

        // Reset during bit 3 with valid asserted: nothing accepted.
        send8(8'hB6);
        dv8 = 1'b0;
        repeat (3) tick();
        res  = 1'b1;
        dv8  = 1'b1;
        din8 = 8'hB6;
        tick();
        res = 1'b0;
        dv8 = 1'b0;
        chk("t4_x",         {31'b0, x0},    32'd0);
        chk("t4_x_valid",   {31'b0, xv0},   32'd0);
        chk("t4_last",      {31'b0, last0}, 32'd0);
        chk("t4_busy",      {31'b0, busy0}, 32'd0);
        chk("t4_din_ready", {31'b0, rdy0},  32'd1);
        tick();
        chk("t4_no_accept", {31'b0, xv0},   32'd0);
        clear_caps();
        send8(8'h0F);
        dv8 = 1'b0;
        repeat (12) tick();
        chk_cap("t4_after_0F", 0, 8, 16'h000F);

        // LSB-first ordering.
        clear_caps();
        send8(8'h0D);
        dv8 = 1'b0;
        repeat (12) tick();
        chk_cap("t5_lsb_0D", 1, 8, 16'h00B0);
        chk_cap("t5_msb_0D", 0, 8, 16'h000D);

        // WIDTH=1 streaming: one word per cycle.
        clear_caps();
        begin
            logic [4:0] seq;
            seq = 5'b10110;
            for (int k = 4; k >= 0; k--) begin
                din1 = seq[k];
                dv1  = 1'b1;
                tick();
                chk("t6_w1_ready", {31'b0, rdy2}, 32'd1);
            end
        end
        dv1 = 1'b0;
        repeat (3) tick();
        chk_cap("t6_w1_seq", 2, 5, 16'h0016);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            dv8  = ($urandom_range(3) != 0);
            din8 = 8'($urandom);
            dv1  = ($urandom_range(3) != 0);
            din1 = 1'($urandom);
            res  = ($urandom_range(49) == 0);
            tick();
        end
        res = 1'b0;
        dv8 = 1'b0;
        dv1 = 1'b0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`.
- `x_valid` qualifies each bit, so the detector stage only advances on real data.
- Back-to-back words stream with no idle gap between them.

Parameters:
- WIDTH, 8: bits per parallel word. Must be >= 1.
- MSB_FIRST, 1: 1 shifts din[WIDTH-1] first; 0 shifts din[0] first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- res  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept din this cycle. Combinational: !busy | last.
- x  output  1  serial data bit, registered.
- x_valid  output  1  x carries a valid bit this cycle, registered.
- last  output  1  current x is the final bit of the word, registered.
- busy  output  1  a word is being shifted out, registered.

Behaviour:
- Reset:
  - Synchronous and active-high, so it is sampled only on a rising clk edge.
  - After the reset edge: x=0, x_valid=0, last=0, busy=0, state IDLE, shift register=0, bit counter=0.
  - din_ready therefore reads 1.
- Handshake:
  - A transfer occurs on a rising edge where din_valid & din_ready = 1.
  - din is sampled only at that edge; the source may change din freely afterwards.
  - While din_ready=0, din_valid is ignored and no data is lost. The source must hold din_valid/din.
- State IDLE (busy=0):
  - x_valid=0, x=0, last=0.
  - A transfer loads the shift register from din and sets the bit counter to WIDTH-1.
  - It also sets busy=1 and moves to SHIFT.
- State SHIFT (busy=1):
  - Each cycle presents one bit on x with x_valid=1.
  - MSB_FIRST=1: x = shift register MSB; the register shifts left each edge.
  - MSB_FIRST=0: x = shift register LSB; the register shifts right each edge.
  - The bit counter decrements each edge.
  - last=1 when the counter is 0, i.e. during the final bit.
- Latency:
  - The first bit appears in the cycle immediately after the accepting edge.
  - A word occupies exactly WIDTH consecutive x_valid cycles.
- End of word (last=1):
  - With a transfer at that edge: the new word is reloaded and its first bit follows in the next cycle. The block stays in SHIFT with no gap and x_valid stays 1.
  - Without a transfer at that edge: return to IDLE. The next cycle has x_valid=0, busy=0, x=0.
- WIDTH=1: every SHIFT cycle is also a last cycle, so last=x_valid always. Continuous din_valid yields one word per cycle.
- Bit counter width: max(1, clog2(WIDTH)). It never wraps below 0; it is reloaded or the state goes to IDLE.
- Reset mid-word: remaining bits are discarded and the block is in IDLE on the next cycle. A din_valid present on the reset edge is NOT accepted (reset has priority).
- No output depends combinationally on din or din_valid. Only din_ready is combinational, and it depends only on internal registers.

Test Plan:
1. Reset, then din=8'hB6, din_valid for one accepting edge (MSB_FIRST=1) -> next 8 cycles x=1,0,1,1,0,1,1,0 with x_valid=1; last=1 only on the 8th; then x_valid=0, busy=0. The downstream detector's `found` pulses on the 0 following 1011.
2. Back-to-back 8'hB0 then 8'h2C, din_valid held high -> 16 contiguous x_valid cycles: 1011 0000 0010 1100. din_ready=1 only in the IDLE cycle and the two last cycles.
3. din_valid=1 with din=8'hFF asserted mid-word (bit 3 of 8'h00) -> not accepted while din_ready=0; accepted at the last edge; eight 1s follow immediately after the eight 0s.
4. res asserted at an edge during bit 3 of 8'hB6, with din_valid=1 -> next cycle x=0, x_valid=0, last=0, busy=0, din_ready=1 and no word accepted. A following 8'h0F yields 0000 1111.
5. MSB_FIRST=0, din=8'h0D -> x=1,0,1,1,0,0,0,0, last on the 8th bit.
6. WIDTH=1, din_valid held with din toggling 1,0,1,1,0 -> x repeats the sequence one cycle later. x_valid=1 and last=1 every cycle; din_ready stays 1.
